uart_cmd_rx: RTL and testbench
==============================

UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter BAUD_DIV, default 325, clk cycles per 1/16-bit tick (50 MHz, 9600 baud).
REQ-002 Parameter IDLE_TIMEOUT, default 500000, clk cycles of RX idle before a pending command is discarded.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rxData  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 byteValid  output  1  one-cycle pulse, byteData valid.
REQ-007 byteData  output  8  last correctly framed byte received.
REQ-008 cmdValid  output  1  one-cycle pulse, cmdCode valid.
REQ-009 cmdCode  output  3  decoded command, held until the next cmdValid.
REQ-010 frameErr  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 parseErr  output  1  one-cycle pulse, byte rejected by the parser.
REQ-012 echoValid  output  1  one-cycle pulse, echoData valid for the TX message loader.
REQ-013 echoData  output  8  byte to echo.

Function
REQ-014 rxData SHALL pass through a 2-flop synchronizer before any use.
REQ-015 A tick counter SHALL count 0..BAUD_DIV-1 and emit one tick per wrap; counting runs continuously.
REQ-016 Receiver states SHALL be R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH.
REQ-017 R_IDLE -> R_START on synchronized falling edge; tick-in-bit counter cleared.
REQ-018 R_START: at tick 8, line high -> R_IDLE (false start, no pulse); line low -> R_DATA.
REQ-019 R_DATA: sample each bit at tick 16 after the previous sample point, LSB first; after bit 7 -> R_STOP.
REQ-020 R_STOP: line high at sample -> byteValid pulse, byteData updated, -> R_IDLE; line low -> frameErr pulse, byte discarded, byteData unchanged, -> R_WAIT_HIGH.
REQ-021 R_WAIT_HIGH -> R_IDLE once the synchronized line is high; no falling edge accepted before then.
REQ-022 Parser states SHALL be P_WAIT_CMD, P_WAIT_CR; parser consumes only byteValid pulses.
REQ-023 P_WAIT_CMD: 'F','L','R','B','S','H' -> latch code, -> P_WAIT_CR; CR(13) or LF(10) ignored; any other byte -> parseErr.
REQ-024 P_WAIT_CR: CR -> cmdValid pulse the cycle after byteValid, cmdCode = latched code, -> P_WAIT_CMD; LF ignored; any other byte -> parseErr, pending discarded, -> P_WAIT_CMD.
REQ-025 Codes: F=CMD_FORWARD 0, L=CMD_LEFT 1, R=CMD_RIGHT 2, B=CMD_REVERSE 3, S=CMD_STOP 4, H=CMD_HOLD 5; lowercase letters are rejected.
REQ-026 In P_WAIT_CR, IDLE_TIMEOUT clk cycles with receiver in R_IDLE SHALL discard the pending code -> P_WAIT_CMD, parseErr pulse.
REQ-027 frameErr while in P_WAIT_CR SHALL discard the pending code -> P_WAIT_CMD (frameErr only, no parseErr).
REQ-028 byteValid, cmdValid, frameErr, parseErr SHALL never be high more than one cycle per event.

Reset
REQ-029 rst SHALL force R_IDLE, P_WAIT_CMD, all counters 0, synchronizer flops 1, all pulse outputs 0, byteData 0, cmdCode CMD_STOP, echoData 0.
REQ-030 rst mid-frame SHALL abandon the byte with no pulse; reception restarts on the next falling edge after release.

Configuration
REQ-031 Macro UART_RX_ECHO_EN defined: echoValid pulses one cycle after every byteValid with echoData = byteData.
REQ-032 Macro UART_RX_ECHO_EN undefined: echo logic absent, echoValid and echoData tied 0; ports remain.

Structure
REQ-033 Shared package uart_pkg SHALL hold CMD_* codes, ASCII constants (CR, LF, command letters), receiver and parser state encodings.
REQ-034 Byte deserializer (REQ-014..021) SHALL be sub-module uart_rx_byte; parser, timeout and echo stay in uart_cmd_rx.

Verification
REQ-035 BAUD_DIV=4; send 'F' then CR -> two byteValid (0x46, 0x0D), one cmdValid with cmdCode=0.
REQ-036 Send 'X' -> byteValid 0x58, parseErr pulse, no cmdValid; then 'S',CR -> cmdCode=4.
REQ-037 Send 'L' with stop bit low -> frameErr, no byteValid; line held low 40 bits -> no further pulses until high; then 'H',CR -> cmdCode=5.
REQ-038 Low glitch of 2 ticks on idle line -> no byteValid, no frameErr.
REQ-039 Send 'R', idle IDLE_TIMEOUT cycles, then CR -> parseErr on timeout, CR ignored, no cmdValid.
REQ-040 rst asserted at data bit 4 of 'B' -> no pulses; after release 'B',CR -> cmdCode=3; with UART_RX_ECHO_EN, echoData 0x42 then 0x0D.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART command types: command codes, ASCII constants, receiver/parser state encodings.
// Latency: n/a (types and a pure decode function); backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    CMD_FORWARD = 3'd0,
    CMD_LEFT    = 3'd1,
    CMD_RIGHT   = 3'd2,
    CMD_REVERSE = 3'd3,
    CMD_STOP    = 3'd4,
    CMD_HOLD    = 3'd5
  } cmd_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT_HIGH
  } rxState_t;

  typedef enum logic {
    P_WAIT_CMD,
    P_WAIT_CR
  } parseState_t;

  typedef struct packed {
    logic ok;
    cmd_t code;
  } cmdDec_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_H  = 8'h48;

  // Only uppercase letters map to commands; everything else reports ok=0.
  function automatic cmdDec_t decodeCmd(input logic [7:0] b);
    cmdDec_t d;
    d.ok   = 1'b1;
    d.code = CMD_STOP;
    case (b)
      ASCII_F: d.code = CMD_FORWARD;
      ASCII_L: d.code = CMD_LEFT;
      ASCII_R: d.code = CMD_RIGHT;
      ASCII_B: d.code = CMD_REVERSE;
      ASCII_S: d.code = CMD_STOP;
      ASCII_H: d.code = CMD_HOLD;
      default: d.ok   = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserializer with 16x oversampling; byteValid/frameErr pulse one clk after the stop-bit sample.
// Latency: ~9.5 bit times from start edge; backpressure: none, bytes are lost if not consumed.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxData,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       frameErr,
  output logic       rxIdle
);

  localparam int DIV_W = $clog2(BAUD_DIV + 1);

  rxState_t         state, stateNext;
  logic             rxMeta, rxSync, rxPrev;
  logic [DIV_W-1:0] divCnt;
  logic             tick;
  logic [3:0]       tickCnt, tickNext;
  logic [2:0]       bitCnt, bitNext;
  logic [7:0]       shiftReg, shiftNext, dataNext;
  logic             byteValidNext, frameErrNext;

  assign tick   = (divCnt == DIV_W'(BAUD_DIV - 1));
  assign rxIdle = (state == R_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta    <= 1'b1;
      rxSync    <= 1'b1;
      rxPrev    <= 1'b1;
      divCnt    <= '0;
      state     <= R_IDLE;
      tickCnt   <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      byteData  <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      rxMeta    <= rxData;
      rxSync    <= rxMeta;
      rxPrev    <= rxSync;
      divCnt    <= tick ? '0 : divCnt + DIV_W'(1);
      state     <= stateNext;
      tickCnt   <= tickNext;
      bitCnt    <= bitNext;
      shiftReg  <= shiftNext;
      byteData  <= dataNext;
      byteValid <= byteValidNext;
      frameErr  <= frameErrNext;
    end
  end

  // Tick phase is free-running, so the start edge lands anywhere within a tick.
  always_comb begin
    stateNext     = state;
    tickNext      = tickCnt;
    bitNext       = bitCnt;
    shiftNext     = shiftReg;
    dataNext      = byteData;
    byteValidNext = 1'b0;
    frameErrNext  = 1'b0;
    case (state)
      R_IDLE: begin
        if (rxPrev && !rxSync) begin
          stateNext = R_START;
          tickNext  = '0;
        end
      end
      R_START: begin
        if (tick) begin
          if (tickCnt == 4'd7) begin
            tickNext  = '0;
            bitNext   = '0;
            stateNext = rxSync ? R_IDLE : R_DATA;
          end else begin
            tickNext = tickCnt + 4'd1;
          end
        end
      end
      R_DATA: begin
        if (tick) begin
          tickNext = tickCnt + 4'd1;
          if (tickCnt == 4'd15) begin
            shiftNext = {rxSync, shiftReg[7:1]};
            if (bitCnt == 3'd7) stateNext = R_STOP;
            else                bitNext   = bitCnt + 3'd1;
          end
        end
      end
      R_STOP: begin
        if (tick) begin
          tickNext = tickCnt + 4'd1;
          if (tickCnt == 4'd15) begin
            if (rxSync) begin
              byteValidNext = 1'b1;
              dataNext      = shiftReg;
              stateNext     = R_IDLE;
            end else begin
              frameErrNext = 1'b1;
              stateNext    = R_WAIT_HIGH;
            end
          end
        end
      end
      R_WAIT_HIGH: begin
        if (rxSync) stateNext = R_IDLE;
      end
      default: stateNext = R_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: "<letter> CR" lines -> cmdValid/cmdCode; optional echo under UART_RX_ECHO_EN.
// Latency: cmdValid one clk after the CR byteValid; backpressure: none, every output is a pulse.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV     = 325,
  parameter int IDLE_TIMEOUT = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxData,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       cmdValid,
  output logic [2:0] cmdCode,
  output logic       frameErr,
  output logic       parseErr,
  output logic       echoValid,
  output logic [7:0] echoData
);

  localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);

  logic        rxIdle;
  parseState_t pState, pStateNext;
  cmd_t        pendCode, pendNext, cmdCodeQ, cmdCodeNext;
  logic        cmdValidNext, parseErrNext;
  logic [TO_W-1:0] toCnt, toCntNext;
  cmdDec_t     dec;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) uRxByte (
    .clk       (clk),
    .rst       (rst),
    .rxData    (rxData),
    .byteValid (byteValid),
    .byteData  (byteData),
    .frameErr  (frameErr),
    .rxIdle    (rxIdle)
  );

  assign cmdCode = cmdCodeQ;
  assign dec     = decodeCmd(byteData);

  always_ff @(posedge clk) begin
    if (rst) begin
      pState   <= P_WAIT_CMD;
      pendCode <= CMD_STOP;
      cmdCodeQ <= CMD_STOP;
      cmdValid <= 1'b0;
      parseErr <= 1'b0;
      toCnt    <= '0;
    end else begin
      pState   <= pStateNext;
      pendCode <= pendNext;
      cmdCodeQ <= cmdCodeNext;
      cmdValid <= cmdValidNext;
      parseErr <= parseErrNext;
      toCnt    <= toCntNext;
    end
  end

  // The idle timer only runs while a command waits for CR and resets on any line activity.
  always_comb begin
    pStateNext   = pState;
    pendNext     = pendCode;
    cmdCodeNext  = cmdCodeQ;
    cmdValidNext = 1'b0;
    parseErrNext = 1'b0;
    toCntNext    = '0;
    case (pState)
      P_WAIT_CMD: begin
        if (byteValid) begin
          if (dec.ok) begin
            pendNext   = dec.code;
            pStateNext = P_WAIT_CR;
          end else if (byteData != ASCII_CR && byteData != ASCII_LF) begin
            parseErrNext = 1'b1;
          end
        end
      end
      P_WAIT_CR: begin
        if (frameErr) begin
          pStateNext = P_WAIT_CMD;
        end else if (byteValid) begin
          if (byteData == ASCII_CR) begin
            cmdValidNext = 1'b1;
            cmdCodeNext  = pendCode;
            pStateNext   = P_WAIT_CMD;
          end else if (byteData != ASCII_LF) begin
            parseErrNext = 1'b1;
            pStateNext   = P_WAIT_CMD;
          end
        end else if (rxIdle) begin
          if (toCnt == TO_W'(IDLE_TIMEOUT - 1)) begin
            parseErrNext = 1'b1;
            pStateNext   = P_WAIT_CMD;
          end else begin
            toCntNext = toCnt + TO_W'(1);
          end
        end
      end
      default: pStateNext = P_WAIT_CMD;
    endcase
  end

`ifdef UART_RX_ECHO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      echoValid <= 1'b0;
      echoData  <= '0;
    end else begin
      echoValid <= byteValid;
      if (byteValid) echoData <= byteData;
    end
  end
`else
  assign echoValid = 1'b0;
  assign echoData  = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at BAUD_DIV=4 (64 clk per bit) with a short idle timeout.
module tb_uart_cmd_rx;

  localparam int BIT_CLKS = 64;
  localparam int TIMEOUT  = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxData = 1'b1;
  logic       byteValid, cmdValid, frameErr, parseErr, echoValid;
  logic [7:0] byteData, echoData;
  logic [2:0] cmdCode;

  int nTests = 0;
  int nFail  = 0;

  int byteCnt = 0, cmdCnt = 0, frameCnt = 0, parseCnt = 0, echoCnt = 0, pulseErr = 0;
  logic [7:0] byteLog[$];
  logic [7:0] echoLog[$];
  logic prevBv = 1'b0, prevCv = 1'b0, prevFe = 1'b0, prevPe = 1'b0;
  int bByte, bCmd, bFrame, bParse, bEcho;

  uart_cmd_rx #(.BAUD_DIV(4), .IDLE_TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxData    (rxData),
    .byteValid (byteValid),
    .byteData  (byteData),
    .cmdValid  (cmdValid),
    .cmdCode   (cmdCode),
    .frameErr  (frameErr),
    .parseErr  (parseErr),
    .echoValid (echoValid),
    .echoData  (echoData)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byteValid) begin byteCnt++; byteLog.push_back(byteData); end
    if (cmdValid)  cmdCnt++;
    if (frameErr)  frameCnt++;
    if (parseErr)  parseCnt++;
    if (echoValid) begin echoCnt++; echoLog.push_back(echoData); end
    if ((byteValid && prevBv) || (cmdValid && prevCv) || (frameErr && prevFe) || (parseErr && prevPe))
      pulseErr++;
    prevBv = byteValid;
    prevCv = cmdValid;
    prevFe = frameErr;
    prevPe = parseErr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    bByte = byteCnt; bCmd = cmdCnt; bFrame = frameCnt; bParse = parseCnt; bEcho = echoCnt;
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxData = 1'b1;
    waitClk(n);
  endtask

  // Leaves the line low after a low stop bit so the caller controls the break.
  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rxData = 1'b0;
    waitClk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxData = b[i];
      waitClk(BIT_CLKS);
    end
    rxData = stopBit;
    waitClk(BIT_CLKS);
    if (stopBit) waitClk(20);
  endtask

  initial begin
    waitClk(5);
    rst = 1'b0;
    waitClk(2);
    check("rst_byteValid", byteValid, 0);
    check("rst_byteData", byteData, 8'h00);
    check("rst_cmdCode", cmdCode, 3'd4);
    check("rst_pulses", {cmdValid, frameErr, parseErr}, 3'b000);
    check("rst_echo", {echoValid, echoData}, 9'h000);

    snap();
    sendByte(8'h46, 1'b1);
    sendByte(8'h0D, 1'b1);
    check("F_byteCnt", byteCnt - bByte, 2);
    check("F_byte0", byteLog[bByte], 8'h46);
    check("F_byte1", byteLog[bByte + 1], 8'h0D);
    check("F_cmdCnt", cmdCnt - bCmd, 1);
    check("F_cmdCode", cmdCode, 3'd0);
    check("F_parseCnt", parseCnt - bParse, 0);

    snap();
    sendByte(8'h58, 1'b1);
    check("X_byte", byteLog[bByte], 8'h58);
    check("X_parseCnt", parseCnt - bParse, 1);
    check("X_cmdCnt", cmdCnt - bCmd, 0);
    sendByte(8'h53, 1'b1);
    sendByte(8'h0D, 1'b1);
    check("S_cmdCnt", cmdCnt - bCmd, 1);
    check("S_cmdCode", cmdCode, 3'd4);

    snap();
    sendByte(8'h4C, 1'b0);
    waitClk(40 * BIT_CLKS);
    check("L_frameCnt", frameCnt - bFrame, 1);
    check("L_byteCnt", byteCnt - bByte, 0);
    check("L_byteData", byteData, 8'h0D);
    idle(100);
    check("L_break_quiet", (byteCnt - bByte) + (frameCnt - bFrame - 1) + (parseCnt - bParse), 0);
    sendByte(8'h48, 1'b1);
    sendByte(8'h0D, 1'b1);
    check("H_cmdCode", cmdCode, 3'd5);
    check("H_cmdCnt", cmdCnt - bCmd, 1);

    snap();
    sendByte(8'h46, 1'b1);
    sendByte(8'h0D, 1'b0);
    idle(100);
    sendByte(8'h0D, 1'b1);
    check("FE_pend_frameCnt", frameCnt - bFrame, 1);
    check("FE_pend_parseCnt", parseCnt - bParse, 0);
    check("FE_pend_cmdCnt", cmdCnt - bCmd, 0);

    snap();
    rxData = 1'b0;
    waitClk(8);
    idle(200);
    check("glitch_byteCnt", byteCnt - bByte, 0);
    check("glitch_frameCnt", frameCnt - bFrame, 0);

    snap();
    sendByte(8'h52, 1'b1);
    idle(TIMEOUT + 100);
    check("TO_parseCnt", parseCnt - bParse, 1);
    sendByte(8'h0D, 1'b1);
    check("TO_cmdCnt", cmdCnt - bCmd, 0);
    check("TO_parse_after_cr", parseCnt - bParse, 1);

    snap();
    rxData = 1'b0;
    waitClk(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rxData = (i == 1);
      waitClk(BIT_CLKS);
    end
    rxData = 1'b0;
    waitClk(BIT_CLKS / 2);
    rst = 1'b1;
    rxData = 1'b1;
    waitClk(10);
    rst = 1'b0;
    idle(2 * BIT_CLKS);
    check("rstB_pulses", (byteCnt - bByte) + (frameCnt - bFrame) + (parseCnt - bParse) + (cmdCnt - bCmd), 0);
    check("rstB_byteData", byteData, 8'h00);
    check("rstB_cmdCode", cmdCode, 3'd4);
    sendByte(8'h42, 1'b1);
    sendByte(8'h0D, 1'b1);
    check("B_cmdCode", cmdCode, 3'd3);
    check("B_cmdCnt", cmdCnt - bCmd, 1);
`ifdef UART_RX_ECHO_EN
    check("B_echoCnt", echoCnt - bEcho, 2);
    check("B_echo0", (echoCnt - bEcho >= 2) ? echoLog[bEcho] : 8'hxx, 8'h42);
    check("B_echo1", (echoCnt - bEcho >= 2) ? echoLog[bEcho + 1] : 8'hxx, 8'h0D);
`else
    check("echo_absent", echoCnt, 0);
`endif

    check("pulse_width", pulseErr, 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
